// File: rtl/final_pkg.sv
// Shared types and defaults for the score collector / argmax slice.
package final_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 32;
  localparam int IDX_W       = 4;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } collect_state_t;
endpackage

// File: rtl/argmax_tracker.sv
// Sequential running-max tracker; the first beat always seeds the max.
module argmax_tracker
  import final_pkg::*;
#(
  parameter int SCORE_W = final_pkg::SCORE_W,
  parameter int IDX_W   = final_pkg::IDX_W
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      load,
  input  logic [IDX_W-1:0]          idx,
  input  logic signed [SCORE_W-1:0] score,
  output logic signed [SCORE_W-1:0] max_val,
  output logic [IDX_W-1:0]          max_idx
);

  always_ff @(posedge clk) begin
    if (clear) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (load && (idx == '0 || score > max_val)) begin
      // strict compare keeps the lowest index on ties
      max_val <= score;
      max_idx <= idx;
    end
  end

endmodule

// File: rtl/score_argmax_collector.sv
// Collects class scores into a result bank and tracks the argmax.
// Optional CPU cross-check enabled by SCORE_ARGMAX_CHECK_SW_EN.
module score_argmax_collector
  import final_pkg::*;
#(
  parameter int NUM_CLASSES = final_pkg::NUM_CLASSES,
  parameter int SCORE_W     = final_pkg::SCORE_W,
  parameter int IDX_W       = final_pkg::IDX_W
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             start,
  input  logic                             score_valid,
  input  logic signed [SCORE_W-1:0]        score_data,
  input  logic                             score_last,
  output logic                             score_ready,
  output logic [NUM_CLASSES*SCORE_W-1:0]   res_flat,
  output logic [IDX_W-1:0]                 hw_digit,
  output logic                             result_valid,
  output logic                             busy,
  output logic                             err_len,
  input  logic [3:0]                       sw_inference
`ifdef SCORE_ARGMAX_CHECK_SW_EN
  ,
  output logic                             sw_mismatch,
  output logic [15:0]                      mismatch_cnt
`endif
);

  collect_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [SCORE_W-1:0] bank [NUM_CLASSES];
  logic beat, at_end, frame_end;
  logic signed [SCORE_W-1:0] unused_max_val;

  assign beat      = score_valid && score_ready;
  assign at_end    = idx_q == IDX_W'(NUM_CLASSES-1);
  assign frame_end = beat && (score_last || at_end);

  always_comb begin
    state_d      = state_q;
    score_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        busy        = 1'b1;
        score_ready = !start;
        if (start)          state_d = COLLECT;
        else if (frame_end) state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (start) state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_len <= 1'b0;
      bank    <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (start) begin
        idx_q   <= '0;
        err_len <= 1'b0;
        bank    <= '{default: '0};
      end else if (beat) begin
        bank[idx_q] <= score_data;
        idx_q       <= idx_q + 1'b1;
        // short frame or missing last flag both mark a bad length
        if (frame_end) err_len <= score_last ^ at_end;
      end
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_res
    assign res_flat[k*SCORE_W +: SCORE_W] = bank[k];
  end

  argmax_tracker #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_tracker (
    .clk     (Clk),
    .clear   (Reset || start),
    .load    (beat),
    .idx     (idx_q),
    .score   (score_data),
    .max_val (unused_max_val),
    .max_idx (hw_digit)
  );

`ifdef SCORE_ARGMAX_CHECK_SW_EN
  logic [3:0] sw_base;
  logic       sw_seen;
  logic       entering_done;

  assign entering_done = (state_q == COLLECT) && (state_d == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_mismatch  <= 1'b0;
      mismatch_cnt <= '0;
      sw_base      <= '0;
      sw_seen      <= 1'b0;
    end else if (start) begin
      sw_mismatch <= 1'b0;
      sw_seen     <= 1'b0;
    end else if (entering_done) begin
      sw_base <= sw_inference;
    end else if (state_q == DONE && !sw_seen &&
                 sw_inference != sw_base &&
                 IDX_W'(sw_inference) != hw_digit) begin
      sw_mismatch <= 1'b1;
      sw_seen     <= 1'b1;
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`else
  logic unused_sw;
  assign unused_sw = ^sw_inference;
`endif

endmodule

// File: tb/tb_score_argmax_collector.sv
// Directed plus randomized bench with a frame-level reference model.
module tb_score_argmax_collector;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;
  logic score_valid = 1'b0;
  logic score_last = 1'b0;
  logic [W-1:0] score_data = '0;
  logic score_ready, result_valid, busy, err_len;
  logic [N*W-1:0] res_flat;
  logic [IW-1:0] hw_digit;
  logic [3:0] sw_inference = '0;
`ifdef SCORE_ARGMAX_CHECK_SW_EN
  logic sw_mismatch;
  logic [15:0] mismatch_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  score_argmax_collector dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .score_valid  (score_valid),
    .score_data   (score_data),
    .score_last   (score_last),
    .score_ready  (score_ready),
    .res_flat     (res_flat),
    .hw_digit     (hw_digit),
    .result_valid (result_valid),
    .busy         (busy),
    .err_len      (err_len),
    .sw_inference (sw_inference)
`ifdef SCORE_ARGMAX_CHECK_SW_EN
    ,
    .sw_mismatch  (sw_mismatch),
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input bit last,
                      input int gap, input bit fin, input string tag);
    int t;
    score_valid = 1'b0;
    repeat (gap) tick();
    score_valid = 1'b1;
    score_data  = v;
    score_last  = last;
    #1;
    t = 0;
    while (!score_ready && t < 20) begin
      tick();
      t++;
    end
    check({tag, "_ready"}, score_ready, 1);
    if (fin) check({tag, "_early_valid"}, result_valid, 0);
    tick();
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  // Frame model: end at last flag or at class N-1, argmax over received beats.
  task automatic frame(input int sc[N], input int last_at, input int gap_max,
                       input bit do_st, input string tag);
    int nb, e_idx, mx;
    bit e_err;
    int eb[N];
    if (do_st) begin
      do_start();
      check({tag, "_busy0"}, busy, 1);
      check({tag, "_err0"}, err_len, 0);
    end
    nb = (last_at < N) ? last_at + 1 : N;
    e_err = (last_at != N - 1);
    for (int k = 0; k < N; k++) eb[k] = (k < nb) ? sc[k] : 0;
    e_idx = 0;
    mx = sc[0];
    for (int k = 1; k < nb; k++)
      if (sc[k] > mx) begin
        mx = sc[k];
        e_idx = k;
      end
    for (int i = 0; i < nb; i++)
      send(sc[i], i == last_at, $urandom_range(gap_max, 0), i == nb - 1, tag);
    check({tag, "_rv"}, result_valid, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy"}, score_ready, 0);
    check({tag, "_digit"}, hw_digit, e_idx);
    check({tag, "_err"}, err_len, e_err);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_res%0d", tag, k), res_flat[k*W +: W], eb[k]);
  endtask

  initial begin
    int sc[N];
    int la;

    // reset and idle with valid high
    repeat (3) tick();
    Reset = 1'b0;
    score_valid = 1'b1;
    repeat (5) tick();
    check("idle_bank", res_flat == '0, 1);
    check("idle_digit", hw_digit, 0);
    check("idle_rv", result_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_err", err_len, 0);
    check("idle_rdy", score_ready, 0);
`ifdef SCORE_ARGMAX_CHECK_SW_EN
    check("idle_swm", sw_mismatch, 0);
    check("idle_cnt", mismatch_cnt, 0);
`endif
    score_valid = 1'b0;

    sc = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    frame(sc, 9, 0, 1, "pi");

    sc = '{-5, -5, -1, -5, -1, -5, -5, -5, -5, -5};
    frame(sc, 9, 1, 1, "tie");

    sc = '{0, 0, 0, 0, 7, 0, 0, 0, 0, 0};
    frame(sc, 4, 0, 1, "short");
    do_start();
    check("short_clr_err", err_len, 0);
    check("short_clr_bank", res_flat == '0, 1);

    sc = '{-9, -3, -7, -3, -8, -2, -6, -2, -4, -1};
    frame(sc, N, 1, 0, "nolast");

    // restart mid-frame, then start held together with valid
    do_start();
    for (int i = 0; i < 6; i++) send(100 + i, 1'b0, 0, 1'b0, "pre");
    start = 1'b1;
    score_valid = 1'b1;
    score_data = 999;
    #1;
    check("rs_rdy_a", score_ready, 0);
    tick();
    check("rs_rdy_b", score_ready, 0);
    tick();
    start = 1'b0;
    score_valid = 1'b0;
    #1;
    check("rs_bank", res_flat == '0, 1);
    check("rs_busy", busy, 1);
    check("rs_digit", hw_digit, 0);
    sc = '{2, 8, 8, 1, 0, 3, 4, 5, 6, 7};
    frame(sc, 9, 2, 0, "rs");

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++)
        sc[k] = ($urandom_range(1, 0) == 1) ? int'($urandom)
                                            : int'($urandom_range(6, 0)) - 3;
      la = $urandom_range(N, 2);
      frame(sc, la, 3, 1, $sformatf("rnd%0d", f));
    end

`ifdef SCORE_ARGMAX_CHECK_SW_EN
    sw_inference = 4'd0;
    sc = '{0, 0, 0, 0, 0, 0, 0, 50, 0, 0};
    frame(sc, 9, 0, 1, "sw1");
    sw_inference = 4'd3;
    tick();
    tick();
    check("sw1_mis", sw_mismatch, 1);
    check("sw1_cnt", mismatch_cnt, 1);
    do_start();
    check("sw_clr_mis", sw_mismatch, 0);
    check("sw_keep_cnt", mismatch_cnt, 1);
    frame(sc, 9, 0, 0, "sw2");
    sw_inference = 4'd7;
    tick();
    tick();
    check("sw2_mis", sw_mismatch, 0);
    check("sw2_cnt", mismatch_cnt, 1);
`endif

    // reset in the middle of a frame
    do_start();
    for (int i = 0; i < 4; i++)
      send(50 + i, 1'b0, $urandom_range(2, 0), 1'b0, "mid");
    score_valid = 1'b1;
    score_data = 77;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_rv", result_valid, 0);
    check("mid_bank", res_flat == '0, 1);
    check("mid_digit", hw_digit, 0);
    check("mid_err", err_len, 0);
    check("mid_rdy", score_ready, 0);
`ifdef SCORE_ARGMAX_CHECK_SW_EN
    check("mid_cnt", mismatch_cnt, 0);
`endif
    repeat (3) tick();
    check("mid_ignore", res_flat == '0, 1);
    score_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
